// File: rtl/pixel_write_fifo.sv
// Pixel write buffer between the compositor and the framebuffer: clips off-screen
// pixels, computes linear addresses, queues them and signals when a frame has drained.
module pixel_write_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4,
  parameter int unsigned X_MAX  = 160,
  parameter int unsigned Y_MAX  = 120,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        in_x,
  input  logic [6:0]        in_y,
  input  logic [7:0]        in_colour,
  input  logic              in_we,
  input  logic              in_done,
  input  logic              fb_ready,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              frame_done,
  output logic              full,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic [7:0]        clip_cnt,
  input  logic              clr_stats
);

  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [CW-1:0]     colour;
  } pix_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_PULSE = 2'd2
  } state_e;

  pix_t              mem_q [DEPTH];
  pix_t              mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              full_q, full_d;
  pix_t              out_q, out_d;
  logic              out_vld_q, out_vld_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        clip_cnt_q, clip_cnt_d;
  logic              done_q, done_d;
  state_e            state_q, state_d;
  logic              frame_done_q, frame_done_d;

  logic              on_screen_c;
  logic              push_req_c;
  logic              clip_c;
  logic              empty_c;
  logic              full_c;
  logic              xfer_c;
  logic              pop_c;
  logic              push_c;
  logic              drop_c;
  pix_t              entry_c;

  // Input qualification and FIFO handshake terms
  always_comb begin
    on_screen_c   = (32'(in_x) < X_MAX) && (32'(in_y) < Y_MAX);
    push_req_c    = in_we & on_screen_c;
    clip_c        = in_we & ~on_screen_c;
    empty_c       = (level_q == '0);
    full_c        = (level_q == LW'(DEPTH));
    xfer_c        = out_vld_q & fb_ready;
    // Output register refills whenever it is free or is being consumed this cycle
    pop_c         = (~out_vld_q | xfer_c) & ~empty_c;
    push_c        = push_req_c & (~full_c | pop_c);
    drop_c        = push_req_c & full_c & ~pop_c;
    entry_c.addr   = ADDR_W'(32'(in_y) * X_MAX + 32'(in_x));
    entry_c.colour = in_colour;
  end

  // Storage array write
  always_comb begin
    mem_d = mem_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = entry_c;
    end
  end

  // Pointers, occupancy, output register and statistics
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    overflow_d = overflow_q;
    clip_cnt_d = clip_cnt_q;
    done_d     = in_done;

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    level_d = level_q + LW'(push_c) - LW'(pop_c);
    full_d  = (level_d == LW'(DEPTH));

    if (pop_c) begin
      out_d     = mem_q[rd_ptr_q];
      out_vld_d = 1'b1;
    end else if (xfer_c) begin
      out_vld_d = 1'b0;
    end

    if (clr_stats) begin
      overflow_d = 1'b0;
      clip_cnt_d = '0;
    end else begin
      overflow_d = overflow_q | drop_c;
      if (clip_c && (clip_cnt_q != 8'hFF)) begin
        clip_cnt_d = clip_cnt_q + 8'd1;
      end
    end
  end

  // Frame completion sequencer
  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_done & ~done_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (empty_c & ~out_vld_q & ~push_c) begin
          state_d = S_PULSE;
        end
      end
      S_PULSE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    frame_done_d = (state_d == S_PULSE);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      full_q       <= 1'b0;
      out_q        <= '0;
      out_vld_q    <= 1'b0;
      overflow_q   <= 1'b0;
      clip_cnt_q   <= '0;
      done_q       <= 1'b0;
      state_q      <= S_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      full_q       <= full_d;
      out_q        <= out_d;
      out_vld_q    <= out_vld_d;
      overflow_q   <= overflow_d;
      clip_cnt_q   <= clip_cnt_d;
      done_q       <= done_d;
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fb_we      = out_vld_q;
  assign fb_addr    = out_q.addr;
  assign fb_data    = out_q.colour;
  assign frame_done = frame_done_q;
  assign full       = full_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign clip_cnt   = clip_cnt_q;

endmodule

// File: tb/tb_pixel_write_fifo.sv
// Directed self-checking bench for pixel_write_fifo.
module tb_pixel_write_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [7:0]  in_colour;
  logic        in_we;
  logic        in_done;
  logic        fb_ready;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [7:0]  fb_data;
  logic        frame_done;
  logic        full;
  logic [4:0]  level;
  logic        overflow;
  logic [7:0]  clip_cnt;
  logic        clr_stats;

  int total = 0;
  int bad   = 0;

  pixel_write_fifo dut (
    .clk(clk), .resetn(resetn), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .in_we(in_we), .in_done(in_done), .fb_ready(fb_ready), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .frame_done(frame_done), .full(full),
    .level(level), .overflow(overflow), .clip_cnt(clip_cnt), .clr_stats(clr_stats)
  );

  always #5 clk = ~clk;

  // Advance one active edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_x = '0; in_y = '0; in_colour = '0; in_we = 1'b0;
    in_done = 1'b0; fb_ready = 1'b0; clr_stats = 1'b0;
    step(); step();
    total++;
    if ({fb_we, fb_addr, fb_data, frame_done, full, level, overflow, clip_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got we=%0b addr=%0d data=%0h fd=%0b full=%0b lvl=%0d ovf=%0b clip=%0d, want all 0",
               fb_we, fb_addr, fb_data, frame_done, full, level, overflow, clip_cnt);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_latency();
    fb_ready = 1'b1;
    in_x = 8'd3; in_y = 7'd2; in_colour = 8'hE0; in_we = 1'b1;
    step();
    in_we = 1'b0;
    total++;
    if (fb_we !== 1'b0 || level !== 5'd1) begin
      bad++; $display("FAIL lat_e0: got we=%0b level=%0d, want we=0 level=1", fb_we, level);
    end
    step();
    total++;
    if (fb_we !== 1'b1 || fb_addr !== 15'd323 || fb_data !== 8'hE0) begin
      bad++; $display("FAIL lat_e1: got we=%0b addr=%0d data=%0h, want 1/323/e0", fb_we, fb_addr, fb_data);
    end
    step();
    total++;
    if (fb_we !== 1'b0 || level !== 5'd0) begin
      bad++; $display("FAIL lat_drop: got we=%0b level=%0d, want 0/0", fb_we, level);
    end
  endtask

  task automatic test_clip();
    int seen;
    in_x = 8'd159; in_y = 7'd119; in_colour = 8'h5A; in_we = 1'b1;
    step();
    in_we = 1'b0;
    step();
    total++;
    if (fb_we !== 1'b1 || fb_addr !== 15'd19199 || fb_data !== 8'h5A) begin
      bad++; $display("FAIL corner_addr: got we=%0b addr=%0d data=%0h, want 1/19199/5a", fb_we, fb_addr, fb_data);
    end
    step();
    seen = 0;
    in_x = 8'd160; in_y = 7'd0; in_we = 1'b1;
    step(); seen += int'(fb_we);
    in_x = 8'd0; in_y = 7'd120;
    step(); seen += int'(fb_we);
    in_we = 1'b0;
    step(); seen += int'(fb_we);
    step(); seen += int'(fb_we);
    total++;
    if (seen != 0 || clip_cnt !== 8'd2) begin
      bad++; $display("FAIL clip_count: got fb_we_cycles=%0d clip=%0d, want 0/2", seen, clip_cnt);
    end
    in_x = 8'd200; in_y = 7'd5; in_we = 1'b1;
    for (int i = 0; i < 260; i++) step();
    in_we = 1'b0;
    step();
    total++;
    if (clip_cnt !== 8'd255) begin
      bad++; $display("FAIL clip_sat: got %0d, want 255", clip_cnt);
    end
    in_we = 1'b1; clr_stats = 1'b1;
    step();
    in_we = 1'b0; clr_stats = 1'b0;
    total++;
    if (clip_cnt !== 8'd0) begin
      bad++; $display("FAIL clr_priority: got clip=%0d, want 0", clip_cnt);
    end
  endtask

  task automatic test_overflow();
    int got[$];
    fb_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      in_x = 8'(i); in_y = 7'd0; in_colour = 8'(i); in_we = 1'b1;
      step();
    end
    in_we = 1'b0;
    total++;
    if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b1 || fb_we !== 1'b1 || fb_addr !== 15'd0) begin
      bad++; $display("FAIL ovf_state: got full=%0b lvl=%0d ovf=%0b we=%0b addr=%0d, want 1/16/1/1/0",
                      full, level, overflow, fb_we, fb_addr);
    end
    step();
    total++;
    if (fb_addr !== 15'd0 || fb_we !== 1'b1) begin
      bad++; $display("FAIL ovf_hold: got we=%0b addr=%0d, want 1/0", fb_we, fb_addr);
    end
    fb_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (fb_we) got.push_back(int'(fb_addr));
      step();
    end
    total++;
    if (got.size() != 17) begin
      bad++; $display("FAIL ovf_count: got %0d pixels, want 17", got.size());
    end
    for (int i = 0; i < got.size() && i < 17; i++) begin
      total++;
      if (got[i] != i) begin
        bad++; $display("FAIL ovf_order[%0d]: got addr %0d, want %0d", i, got[i], i);
      end
    end
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_clear: got %0b, want 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    int got[$];
    int exp[$];
    int ovf_seen;
    fb_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_x = 8'(i); in_y = 7'd0; in_we = 1'b1; exp.push_back(i);
      step();
    end
    total++;
    if (full !== 1'b1) begin
      bad++; $display("FAIL b2b_full: got %0b, want 1", full);
    end
    fb_ready = 1'b1;
    ovf_seen = 0;
    for (int c = 0; c < 60; c++) begin
      if (fb_we) got.push_back(int'(fb_addr));
      if (c < 20) begin
        in_x = 8'(100 + c); in_y = 7'd1; in_we = 1'b1; exp.push_back(260 + c);
      end else begin
        in_we = 1'b0;
      end
      step();
      ovf_seen += int'(overflow);
    end
    total++;
    if (ovf_seen != 0 || got.size() != exp.size()) begin
      bad++; $display("FAIL b2b_summary: got ovf_cycles=%0d pixels=%0d, want 0/%0d", ovf_seen, got.size(), exp.size());
    end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++;
      if (got[i] != exp[i]) begin
        bad++; $display("FAIL b2b_order[%0d]: got addr %0d, want %0d", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_frame_done();
    int pulses;
    int pulse_at;
    int early;
    fb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_x = 8'(i); in_y = 7'd3; in_we = 1'b1;
      step();
    end
    in_we = 1'b0;
    in_done = 1'b1;
    early = 0;
    for (int c = 0; c < 4; c++) begin
      step(); early += int'(frame_done);
    end
    total++;
    if (early != 0) begin
      bad++; $display("FAIL fd_early: got %0d pulses while stalled, want 0", early);
    end
    fb_ready = 1'b1;
    pulses = 0; pulse_at = -1;
    for (int c = 0; c < 20; c++) begin
      if (frame_done) begin
        pulses++;
        if (pulse_at < 0) pulse_at = c;
      end
      step();
    end
    total++;
    if (pulses != 1 || pulse_at != 6) begin
      bad++; $display("FAIL fd_pulse: got pulses=%0d at sample %0d, want 1 at 6", pulses, pulse_at);
    end
    in_done = 1'b0;
    step();
    in_done = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step(); pulses += int'(frame_done);
    end
    total++;
    if (pulses != 1) begin
      bad++; $display("FAIL fd_retrigger: got %0d pulses, want 1", pulses);
    end
    in_done = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int stale;
    fb_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_x = 8'(i); in_y = 7'd4; in_we = 1'b1;
      step();
    end
    in_we = 1'b0;
    in_done = 1'b1;
    step();
    total++;
    if (level !== 5'd8 || fb_we !== 1'b1) begin
      bad++; $display("FAIL mid_pre: got level=%0d we=%0b, want 8/1", level, fb_we);
    end
    resetn = 1'b0;
    step();
    total++;
    if (fb_we !== 1'b0 || level !== 5'd0 || frame_done !== 1'b0 || full !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got we=%0b lvl=%0d fd=%0b full=%0b, want 0/0/0/0", fb_we, level, frame_done, full);
    end
    in_done = 1'b0;
    fb_ready = 1'b1;
    resetn = 1'b1;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      step(); stale += int'(fb_we) + int'(frame_done);
    end
    total++;
    if (stale != 0) begin
      bad++; $display("FAIL mid_stale: got %0d stale events, want 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_clip();
    test_overflow();
    test_back_to_back();
    test_frame_done();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
